// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg: word type and sizing helpers shared by the FIFO and reader |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_WIDTH = 32;

    typedef logic [FIFO_WIDTH-1:0] word_t;

    // Counter width for a modulo-n counter; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_reader_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_reader_buf: two-entry in-order buffer, slot 0 is the head       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_reader_buf import fifo_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_slot0;
    logic [WIDTH-1:0] r_slot1;
    logic [1:0]       r_count;

    // The caller guarantees no write into a full buffer and no pop from an empty one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= 2'd0;
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            if (pop) begin
                if (r_count == 2'd2) begin
                    r_slot0 <= r_slot1;
                    if (wr_en) begin
                        r_slot1 <= wr_data;
                    end
                end else if (wr_en) begin
                    r_slot0 <= wr_data;
                end
            end else if (wr_en) begin
                if (r_count == 2'd0) begin
                    r_slot0 <= wr_data;
                end else begin
                    r_slot1 <= wr_data;
                end
            end
            r_count <= r_count + {1'b0, wr_en} - {1'b0, pop};
        end
    end

    assign count     = r_count;
    assign head_data = r_slot0;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_reader: drains a 1-cycle-latency FIFO into a framed stream      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_reader import fifo_pkg::*; #(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int BURST = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int                  c_BEAT_W    = ctr_width(BURST);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(BURST - 1);

    logic                r_inflight;
    logic [c_BEAT_W-1:0] r_beat;
    logic [1:0]          w_count;
    logic [2:0]          w_occ;
    logic                w_pop_out;

    fifo_reader_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (r_inflight),
        .wr_data   (fifo_rd_data),
        .pop       (w_pop_out),
        .count     (w_count),
        .head_data (out_data)
    );

    assign out_valid = (w_count != 2'd0);
    assign w_pop_out = out_valid && out_ready;

    // Occupancy after this edge, counting the word already in flight.
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop_out};

    // reset_n gating keeps the pop request low while the reader is held in reset.
    assign fifo_rd_en = reset_n && enable && !fifo_empty && (w_occ < 3'd2);

    assign out_last = out_valid && (r_beat == c_BEAT_LAST);
    assign busy     = out_valid || r_inflight;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 1'b0;
            r_beat     <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop_out) begin
                r_beat <= (r_beat == c_BEAT_LAST) ? '0 : r_beat + c_BEAT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
# fifo_reader

Read-side drain stage that sits directly downstream of the synchronous FIFO. It issues pops against the FIFO's registered, one-cycle-latency read port and re-presents the words as a valid/ready stream. The stream is framed into fixed-length bursts with a `last` marker. A two-entry output buffer absorbs the FIFO read latency, so a continuously ready consumer sees one word per cycle.

## Interface
- `WIDTH`, 32: data word width; must match the upstream FIFO.
- `BURST`, 8: beats per burst; ≥1. `out_last` marks every BURST-th accepted beat.

- `clock`  in  1  rising-edge clock, shared with the FIFO.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  permits new FIFO pops; buffered and in-flight words still drain when low.
- `fifo_empty`  in  1  FIFO empty flag, combinational from the FIFO.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `fifo_rd_data`  in  WIDTH  FIFO read data; valid the cycle after an accepted pop.
- `out_data`  out  WIDTH  head word of the buffer.
- `out_valid`  out  1  head word present.
- `out_last`  out  1  head word closes a burst; only meaningful while `out_valid` is high.
- `out_ready`  in  1  consumer accepts the head word this cycle.
- `busy`  out  1  a word is buffered or in flight.

## Operation
- **State**
  - `count` (0..2): words held in the buffer.
  - `inflight` (0/1): a pop was issued last cycle.
  - `beat` (0..BURST-1): burst position.
- **Pop decision** (combinational)
  - `pop_out = out_valid && out_ready`.
  - `fifo_rd_en = enable && !fifo_empty && (count + inflight - pop_out) < 2`.
  - The FIFO only advances when `!fifo_empty`, so every asserted `fifo_rd_en` is a real pop.
- **Capture**
  - At the edge after `fifo_rd_en` was high, `inflight` is 1.
  - During that cycle, `fifo_rd_data` is written into the buffer tail.
  - Same-cycle capture and pop are allowed.
  - `count_next = count + inflight - pop_out`.
- **Output**
  - `out_valid = (count != 0)`.
  - `out_data` is the oldest entry.
  - `out_last = out_valid && (beat == BURST-1)`.
- **Beat counter**
  - Increments on `pop_out`.
  - Wraps to 0 after BURST-1.
  - Unaffected by `enable` or by stalls.
- `busy = (count != 0) || inflight`.
- **Reset** (async assert, clears everything)
  - `count`, `inflight` and `beat` go to 0.
  - All outputs read 0.
  - Buffer contents are don't-care, but `out_data` reads 0.
  - A word in flight at reset is dropped; the FIFO is reset in the same domain, so nothing is lost silently.
- **Stall**
  - `out_valid` high with `out_ready` low holds `out_data` and `out_last` stable.
  - No overflow can occur: the pop condition reserves buffer space for the in-flight word.
- **`enable` low mid-stream**
  - No new pops are issued.
  - The in-flight word still lands in the buffer.
  - All buffered words remain deliverable.

## Timing
- **Latency**: pop issued at edge N; data captured at edge N+1; `out_valid` high after edge N+1.
- Empty pipeline: `fifo_empty` falling to `out_valid` rising takes 2 cycles.
- **Throughput**: 1 word/cycle sustained with `out_ready` held high and the FIFO non-empty.
- `fifo_rd_en`, `out_valid` and `out_last` are glitch-free functions of registers plus `out_ready`, `enable` and `fifo_empty`. No combinational path runs from `fifo_rd_data` to any output other than through the buffer.
- **Handshake**: once `out_valid` rises, it stays high with data unchanged until accepted (AXI-stream rule).

## Structure
- Shared package `fifo_pkg`: `WIDTH` default and the `word_t` typedef, used by both the FIFO and this block.
- One sub-module, `fifo_reader_buf`: the 2-entry buffer with write and pop ports and a `count` output.
- The top level holds the pop decision, the `inflight` flag and the beat counter.
- Target size: 150–250 RTL lines total.

## Test plan
- **Basic drain**: FIFO holds 0x11, 0x22, 0x33; `enable`=1, `out_ready`=1.
  - `out_valid` first rises 2 cycles after release.
  - Words 0x11, 0x22, 0x33 appear on consecutive cycles, then `out_valid` drops.
- **Burst framing**: BURST=4; 10 words streamed.
  - `out_last` is high on beats 4 and 8 only.
  - After beat 10, `beat` holds 2.
- **Backpressure**: `out_ready` low for 5 cycles mid-stream.
  - `fifo_rd_en` deasserts once `count`=2.
  - `out_data` is stable throughout the stall.
  - No word is lost or duplicated.
- **Enable gating**: drop `enable` while a pop is in flight.
  - The in-flight word is still delivered.
  - `fifo_rd_en` stays 0.
  - `busy` falls once the buffer drains.
- **Empty boundary**: FIFO goes empty after 1 word.
  - Exactly 1 word is delivered.
  - `fifo_rd_en` is never asserted while `fifo_empty`=1.
- **Reset mid-operation**: assert `reset_n`=0 with `count`=2 and a pop in flight.
  - All outputs go to 0 immediately, asynchronously.
  - After release, `beat` restarts at 0.
